sub_bytes_iter: RTL

- Parametrised, sequential SubBytes engine for the AES core.
- Substitutes a 128-bit state through LANES S-box instances, time-multiplexed over 16/LANES cycles.
- Supports forward and inverse (InvSubBytes) mode and valid/ready handshakes on both sides.
- Sits between the round-key-add stage and shift_rows; lets area-constrained builds trade S-box count for latency.

---
 rtl/aes_pkg.sv | 42 ++++
 rtl/sbox_dual.sv | 18 +
 rtl/sub_bytes_iter.sv | 80 ++++++++
 3 files changed

// File: rtl/aes_pkg.sv
// aes_pkg: shared AES block widths, SubBytes engine states and S-box tables.
package aes_pkg;
    localparam int AES_BLOCK_W = 128;
    localparam int AES_BYTES = 16;
    typedef enum logic [1:0] {IDLE, BUSY, DONE} sb_state_t;
    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };
    localparam logic [7:0] INV_SBOX [256] = '{
        8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
        8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
        8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
        8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
        8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
        8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
        8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
        8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
        8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
        8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
        8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
        8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
        8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
        8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
        8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
        8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
    };
endpackage

// File: rtl/sbox_dual.sv
// sbox_dual: combinational byte substitution, forward or inverse selected by inv.
module sbox_dual
    import aes_pkg::*;
#(
    parameter bit INVERSE_EN = 1'b1
) (
    input  logic [7:0] x,
    input  logic       inv,
    output logic [7:0] y
);
    if (INVERSE_EN) begin : g_inv
        assign y = inv ? INV_SBOX[x] : SBOX[x];
    end else begin : g_fwd
        logic unused_inv;
        assign unused_inv = inv;
        assign y = SBOX[x];
    end
endmodule

// File: rtl/sub_bytes_iter.sv
// sub_bytes_iter: SubBytes/InvSubBytes over a 128-bit state using LANES S-boxes,
// one byte group per cycle for 16/LANES cycles, valid/ready on both sides.
module sub_bytes_iter
    import aes_pkg::*;
#(
    parameter int LANES      = 4,
    parameter bit INVERSE_EN = 1'b1
) (
    input  logic         iClk,
    input  logic         iRst,
    input  logic         iValid,
    output logic         oReady,
    input  logic         iInv,
    input  logic [0:127] iState,
    output logic         oValid,
    input  logic         iReady,
    output logic [0:127] oState,
    output logic         oBusy
);
    localparam int N  = AES_BYTES / LANES;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16)) begin : g_bad_lanes
        $error("sub_bytes_iter: LANES must be 1, 2, 4, 8 or 16");
    end

    sb_state_t            state, nxt;
    logic [CW-1:0]        cnt;
    logic                 mode, last;
    logic [0:AES_BLOCK_W-1] work, work_nxt;
    logic [3:0]           base;
    logic [7:0]           sub [LANES];

    assign last = cnt == CW'(N - 1);
    assign base = 4'(cnt) * 4'(LANES);

    // Each lane substitutes byte base+j of the current group.
    for (genvar j = 0; j < LANES; j++) begin : g_lane
        sbox_dual #(.INVERSE_EN(INVERSE_EN)) u_sbox (
            .x   (work[{base + 4'(j), 3'b000} +: 8]),
            .inv (mode),
            .y   (sub[j])
        );
    end

    always_comb begin
        work_nxt = work;
        for (int j = 0; j < LANES; j++) work_nxt[{base + 4'(j), 3'b000} +: 8] = sub[j];
    end

    always_comb begin
        nxt = (state == IDLE) ? (iValid ? BUSY : IDLE) :
              (state == BUSY) ? (last ? DONE : BUSY) :
                                (iReady ? IDLE : DONE);
    end

    always_ff @(posedge iClk) begin
        if (iRst) begin
            state <= IDLE;
            cnt   <= '0;
            work  <= '0;
            mode  <= 1'b0;
        end else begin
            state <= nxt;
            if (state == IDLE && iValid) begin
                work <= iState;
                mode <= INVERSE_EN & iInv;
                cnt  <= '0;
            end else if (state == BUSY) begin
                work <= work_nxt;
                cnt  <= last ? cnt : cnt + 1'b1;
            end
        end
    end

    assign oReady = state == IDLE;
    assign oBusy  = state == BUSY;
    assign oValid = state == DONE;
    assign oState = work;
endmodule
